// File: rtl/priority_circuit_top.sv
// Three independently implemented 4-bit priority lanes plus a registered status stage.
// Lanes are combinational; status outputs lag by one clk cycle. No backpressure.

// Lane "sv": one-hot of the most-significant asserted request, written as an if/else chain.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module priority_lane_sv #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      if (a[3])
         y[3] = 1'b1;
      else if (a[2])
         y[2] = 1'b1;
      else if (a[1])
         y[1] = 1'b1;
      else if (a[0])
         y[0] = 1'b1;
   end

endmodule

// Lane "v": same priority function expressed as flat sum-of-products equations.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module priority_lane_v #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   assign y[3] = a[3];
   assign y[2] = ~a[3] & a[2];
   assign y[1] = ~a[3] & ~a[2] & a[1];
   assign y[0] = ~a[3] & ~a[2] & ~a[1] & a[0];

endmodule

// Lane "vhd": same priority function written as a wildcard case table.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module priority_lane_vhd #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      casez (a)
         4'b1???: y = 4'b1000;
         4'b01??: y = 4'b0100;
         4'b001?: y = 4'b0010;
         4'b0001: y = 4'b0001;
         default: y = 4'b0000;
      endcase
   end

endmodule

// Wrapper: three lanes side by side with a clocked status stage that flags lane disagreement.
// Latency: y_* combinational; *_q outputs one cycle after the inputs they describe.
// Backpressure: none; status registers update on every rising clk edge.
module priority_circuit_top #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] a_sv,
   output logic [W-1:0] y_sv,
   input  logic [W-1:0] a_v,
   output logic [W-1:0] y_v,
   input  logic [W-1:0] a_vhd,
   output logic [W-1:0] y_vhd,
   output logic [W-1:0] y_sv_q,
   output logic [W-1:0] y_v_q,
   output logic [W-1:0] y_vhd_q,
   output logic [2:0]   any_q,
   output logic         mismatch_q,
   output logic         in_diff_q
);

   logic in_diff;
   logic out_diff;

   priority_lane_sv #(.W(W)) u_lane_sv (
      .a (a_sv),
      .y (y_sv)
   );

   priority_lane_v #(.W(W)) u_lane_v (
      .a (a_v),
      .y (y_v)
   );

   priority_lane_vhd #(.W(W)) u_lane_vhd (
      .a (a_vhd),
      .y (y_vhd)
   );

   assign in_diff  = !((a_sv == a_v) && (a_v == a_vhd));
   assign out_diff = !((y_sv == y_v) && (y_v == y_vhd));

   // A lane disagreement only counts when every lane saw the same request vector.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_sv_q     <= '0;
         y_v_q      <= '0;
         y_vhd_q    <= '0;
         any_q      <= '0;
         in_diff_q  <= 1'b0;
         mismatch_q <= 1'b0;
      end else begin
         y_sv_q     <= y_sv;
         y_v_q      <= y_v;
         y_vhd_q    <= y_vhd;
         any_q      <= {(a_vhd != '0), (a_v != '0), (a_sv != '0)};
         in_diff_q  <= in_diff;
         mismatch_q <= !in_diff && out_diff;
      end
   end

endmodule

// File: tb/tb_priority_circuit_top.sv
// Directed plan steps followed by randomized lanes, checked against a plain arithmetic model.
module tb_priority_circuit_top;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] a_sv, a_v, a_vhd;
   logic [3:0] y_sv, y_v, y_vhd;
   logic [3:0] y_sv_q, y_v_q, y_vhd_q;
   logic [2:0] any_q;
   logic       mismatch_q, in_diff_q;

   int n_vec = 0;
   int n_err = 0;

   // Registered values the model expects at the next sample point.
   logic [3:0] e_ysv_q, e_yv_q, e_yvhd_q;
   logic [2:0] e_any_q;
   logic       e_diff_q;

   always #5 clk = ~clk;

   priority_circuit_top #(.W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .a_sv       (a_sv),
      .y_sv       (y_sv),
      .a_v        (a_v),
      .y_v        (y_v),
      .a_vhd      (a_vhd),
      .y_vhd      (y_vhd),
      .y_sv_q     (y_sv_q),
      .y_v_q      (y_v_q),
      .y_vhd_q    (y_vhd_q),
      .any_q      (any_q),
      .mismatch_q (mismatch_q),
      .in_diff_q  (in_diff_q)
   );

   // Largest power of two not exceeding a; zero for a zero request.
   function automatic logic [3:0] model_prio(input logic [3:0] a);
      int v;
      int p;
      v = int'(a);
      if (v == 0) return 4'd0;
      p = 8;
      while (p > v) p = p / 2;
      return 4'(p);
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Drive just after posedge, check at the following negedge, then update the register model.
   task automatic step(input logic [3:0] s, input logic [3:0] v, input logic [3:0] h,
                       input logic rst);
      @(posedge clk);
      #1;
      a_sv  = s;
      a_v   = v;
      a_vhd = h;
      reset = rst;
      @(negedge clk);
      chk("y_sv",       y_sv,              model_prio(s));
      chk("y_v",        y_v,               model_prio(v));
      chk("y_vhd",      y_vhd,             model_prio(h));
      chk("y_sv_q",     y_sv_q,            e_ysv_q);
      chk("y_v_q",      y_v_q,             e_yv_q);
      chk("y_vhd_q",    y_vhd_q,           e_yvhd_q);
      chk("any_q",      {1'b0, any_q},     {1'b0, e_any_q});
      chk("in_diff_q",  {3'b0, in_diff_q}, {3'b0, e_diff_q});
      chk("mismatch_q", {3'b0, mismatch_q}, 4'b0000);
      if (rst) begin
         e_ysv_q  = 4'd0;
         e_yv_q   = 4'd0;
         e_yvhd_q = 4'd0;
         e_any_q  = 3'd0;
         e_diff_q = 1'b0;
      end else begin
         e_ysv_q  = model_prio(s);
         e_yv_q   = model_prio(v);
         e_yvhd_q = model_prio(h);
         e_any_q  = {(h != 0), (v != 0), (s != 0)};
         e_diff_q = !(s == v && v == h);
      end
   endtask

   initial begin
      logic [3:0] r;
      reset = 1'b1;
      a_sv  = 4'd0;
      a_v   = 4'd0;
      a_vhd = 4'd0;
      e_ysv_q  = 4'd0;
      e_yv_q   = 4'd0;
      e_yvhd_q = 4'd0;
      e_any_q  = 3'd0;
      e_diff_q = 1'b0;
      repeat (2) @(posedge clk);

      // Exhaustive sweep, identical lanes.
      for (int i = 0; i < 16; i++) step(4'(i), 4'(i), 4'(i), 1'b0);

      // Timing: 0110 -> 0100 combinationally, registered one cycle later.
      step(4'b0110, 4'b0110, 4'b0110, 1'b0);
      step(4'b0110, 4'b0110, 4'b0110, 1'b0);

      // Reset pulse while holding 1011.
      step(4'b1011, 4'b1011, 4'b1011, 1'b0);
      step(4'b1011, 4'b1011, 4'b1011, 1'b1);
      step(4'b1011, 4'b1011, 4'b1011, 1'b0);
      step(4'b1011, 4'b1011, 4'b1011, 1'b0);

      // Lane independence, then zero input.
      step(4'b0001, 4'b0100, 4'b0000, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0);
      step(4'b0000, 4'b0000, 4'b0000, 1'b0);

      // Back-to-back changes.
      step(4'b1000, 4'b1000, 4'b1000, 1'b0);
      step(4'b0001, 4'b0001, 4'b0001, 1'b0);
      step(4'b1111, 4'b1111, 4'b1111, 1'b0);
      step(4'b1111, 4'b1111, 4'b1111, 1'b0);

      // Randomized: half the steps share one vector across lanes, occasional reset.
      for (int k = 0; k < 200; k++) begin
         r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1)
            step(r, r, r, ($urandom_range(0, 15) == 0));
         else
            step(r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/priority_circuit_top.md
Name: priority_circuit_top

Overview:
- Three independent 4-bit priority circuits ("sv", "v", "vhd" lanes) in one wrapper, for cross-language equivalence checking.
- Each lane drives a one-hot output marking the highest-priority (most-significant) asserted input bit.
- Lane outputs are combinational.
- A clocked status stage registers each lane's result and flags lane disagreement.
- Sits as a leaf/demonstration block; all lanes are normally driven with identical stimulus.

Parameters:
- W, 4, input/output width of each lane. The fixed priority function below is defined for W=4.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset; affects registered status only
- a_sv  input  4  lane sv request vector
- y_sv  output  4  lane sv one-hot priority result (combinational)
- a_v  input  4  lane v request vector
- y_v  output  4  lane v one-hot priority result (combinational)
- a_vhd  input  4  lane vhd request vector
- y_vhd  output  4  lane vhd one-hot priority result (combinational)
- y_sv_q  output  4  registered y_sv
- y_v_q  output  4  registered y_v
- y_vhd_q  output  4  registered y_vhd
- any_q  output  3  registered "any request" per lane: bit0 = sv, bit1 = v, bit2 = vhd; bit set when that lane's a != 0
- mismatch_q  output  1  registered flag: all three a inputs equal but the y outputs differ
- in_diff_q  output  1  registered flag: the three a inputs are not all equal

Behaviour:
- Priority function, identical for every lane (a = lane input, y = lane output):
  - y[3] = a[3]
  - y[2] = ~a[3] & a[2]
  - y[1] = ~a[3] & ~a[2] & a[1]
  - y[0] = ~a[3] & ~a[2] & ~a[1] & a[0]
  - a = 0000 gives y = 0000.
- y is at most one-hot; the lower bits of a are don't-care once a higher bit is set.
- Lanes are purely combinational with zero-cycle latency.
  - No dependence on clk or reset.
  - y is valid within the same half clock period the input changes (the bench applies at posedge and checks at negedge).
- Lanes are separate instances/implementations with no shared logic between them, so each can be checked independently.
- Registered stage, updated on every rising clk edge:
  - y_*_q <= y_*
  - any_q <= {a_vhd != 0, a_v != 0, a_sv != 0}
  - in_diff_q <= !(a_sv == a_v && a_v == a_vhd)
  - mismatch_q <= !in_diff && !(y_sv == y_v && y_v == y_vhd)
- Registered outputs lag the combinational outputs by exactly 1 cycle.
- Reset:
  - When reset = 1 at a rising edge, all registered outputs become 0 (y_*_q = 0000, any_q = 000, in_diff_q = 0, mismatch_q = 0).
  - Reset has priority over the update.
  - Combinational y_* are unaffected by reset.
- Reset asserted mid-stream clears registers on the next edge. The first edge after deassertion captures current inputs normally.
- X/Z inputs: no requirement; the outputs may propagate X.
- mismatch_q must read 0 in any correct implementation; it exists as a self-check.

Test Plan:
- Exhaustive sweep: drive a_sv = a_v = a_vhd over all 16 values 0000..1111, one per cycle. Required:
  - 0000 → 0000
  - 0001 → 0001
  - 001x → 0010
  - 01xx → 0100
  - 1xxx → 1000
  - all three lanes equal; mismatch_q = 0; in_diff_q = 0.
- Timing: apply a = 0110 at posedge → y = 0100 by the following negedge; y_*_q = 0100 after the next posedge (1-cycle lag).
- Reset: hold a = 1011, pulse reset for 1 cycle → registered outputs all 0 that cycle while y_* stays 1000; next cycle y_*_q = 1000 and any_q = 111.
- Lane independence: a_sv = 0001, a_v = 0100, a_vhd = 0000 → y_sv = 0001, y_v = 0100, y_vhd = 0000; next cycle any_q = 011, in_diff_q = 1, mismatch_q = 0.
- Zero input: all lanes 0000 → y_* = 0000; any_q = 000 next cycle.
- Back-to-back changes: 1000 → 0001 → 1111 on consecutive cycles → y = 1000, 0001, 1000 with no glitch at the sample point, and registered copies following 1 cycle later.
